nexys_starship_hazard_gen: RTL and testbench

Hazard generator for Nexys Starship: the upstream stage feeding the four repair state machines (left, right, up, down). It provides a free-running LFSR, the slow `timer_clk` used by the repair SMs' delay counters, one-cycle break pulses (`LR_random`, `RR_random`, `UR_random`, `DR_random`), and the `random_hex` repair combo latched with each pulse. Pulse rate scales with a difficulty level; pulses are only issued while the game is playing.

---
 rtl/nexys_starship_hazard_gen_if.sv | 27 ++
 rtl/nexys_starship_hazard_gen.sv | 131 +++++++++++++
 tb/tb_nexys_starship_hazard_gen.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nexys_starship_hazard_gen_if.sv
// Hazard generator bus: game control inputs plus timer, break pulses and repair combo.
//   master: drives play_flag/gameover_ctrl/level, observes generator outputs
//   slave : the hazard generator itself
interface nexys_starship_hazard_gen_if;
    logic       play_flag;
    logic       gameover_ctrl;
    logic [1:0] level;
    logic       timer_clk;
    logic       LR_random;
    logic       RR_random;
    logic       UR_random;
    logic       DR_random;
    logic [3:0] random_hex;
    logic [7:0] break_count;

    modport master (
        output play_flag, gameover_ctrl, level,
        input  timer_clk, LR_random, RR_random, UR_random, DR_random,
               random_hex, break_count
    );

    modport slave (
        input  play_flag, gameover_ctrl, level,
        output timer_clk, LR_random, RR_random, UR_random, DR_random,
               random_hex, break_count
    );
endinterface

// File: rtl/nexys_starship_hazard_gen.sv
// Hazard generator: free-running LFSR, slow timer_clk divider, and one-cycle
// break pulses with a latched repair combo, rate scaled by difficulty level.
//   Clk   : system clock
//   Reset : synchronous, active-high
//   bus   : slave side of nexys_starship_hazard_gen_if (game control in,
//           timer_clk / *_random pulses / random_hex / break_count out)
module nexys_starship_hazard_gen #(
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int unsigned TICK_DIV       = 50_000_000,
    parameter logic [7:0]  BREAK_THRESH   = 8'd16,
    parameter int unsigned COOLDOWN_TICKS = 2
) (
    input  logic                          Clk,
    input  logic                          Reset,
    nexys_starship_hazard_gen_if.slave    bus
);

    localparam int unsigned DIV_W    = $clog2(TICK_DIV);
    localparam int unsigned HALF_DIV = TICK_DIV / 2;
    localparam int unsigned CD_W     = $clog2(COOLDOWN_TICKS + 1);
    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] FB_MASK  = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_COOL
    } state_e;

    state_e            state_q;
    logic [15:0]       lfsr_q;
    logic [DIV_W-1:0]  div_q;
    logic              timer_q;
    logic [3:0]        pulse_q;     // {LR, RR, UR, DR}
    logic [3:0]        hex_q;
    logic [7:0]        count_q;
    logic [CD_W-1:0]   cool_q;

    logic [15:0]       lfsr_d;
    logic [DIV_W-1:0]  div_d;
    logic              tick_c;
    logic [9:0]        thr_wide_c;
    logic [7:0]        thr_c;
    logic              win_c;
    logic [3:0]        hex_c;
    logic [3:0]        target_c;

    // Next LFSR / divider values, level threshold and break decision.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? FB_MASK : 16'h0000);
        if (lfsr_q == 16'h0000) begin
            lfsr_d = 16'h0001;
        end

        tick_c = (div_q == DIV_W'(TICK_DIV - 1));
        div_d  = tick_c ? '0 : div_q + DIV_W'(1);

        case (bus.level)
            2'd0:    thr_wide_c = {2'b00, BREAK_THRESH};
            2'd1:    thr_wide_c = {1'b0, BREAK_THRESH, 1'b0};
            2'd2:    thr_wide_c = {BREAK_THRESH, 2'b00};
            default: thr_wide_c = 10'd255;
        endcase
        thr_c = (thr_wide_c > 10'd255) ? 8'hFF : thr_wide_c[7:0];

        win_c    = (lfsr_q[7:0] < thr_c);
        hex_c    = (lfsr_q[15:12] == 4'h0) ? 4'h1 : lfsr_q[15:12];
        target_c = 4'b1000 >> lfsr_q[9:8];
    end

    // Game FSM with all outputs registered; LFSR and divider run in every state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED_EFF;
            div_q   <= '0;
            timer_q <= 1'b0;
            pulse_q <= 4'h0;
            hex_q   <= 4'h1;
            count_q <= 8'd0;
            cool_q  <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            div_q   <= div_d;
            timer_q <= (div_d >= DIV_W'(HALF_DIV));
            pulse_q <= 4'h0;

            if (bus.gameover_ctrl) begin
                state_q <= ST_IDLE;
                cool_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.play_flag) begin
                            state_q <= ST_RUN;
                            count_q <= 8'd0;
                        end
                    end
                    ST_RUN: begin
                        if (tick_c && win_c) begin
                            pulse_q <= target_c;
                            hex_q   <= hex_c;
                            count_q <= (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                            cool_q  <= CD_W'(COOLDOWN_TICKS);
                            state_q <= ST_COOL;
                        end
                    end
                    ST_COOL: begin
                        // The tick that empties the counter returns to RUN without a compare.
                        if (tick_c) begin
                            cool_q <= cool_q - CD_W'(1);
                            if (cool_q == CD_W'(1)) begin
                                state_q <= ST_RUN;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.timer_clk   = timer_q;
    assign bus.LR_random   = pulse_q[3];
    assign bus.RR_random   = pulse_q[2];
    assign bus.UR_random   = pulse_q[1];
    assign bus.DR_random   = pulse_q[0];
    assign bus.random_hex  = hex_q;
    assign bus.break_count = count_q;

endmodule

// File: tb/tb_nexys_starship_hazard_gen.sv
// Bench for nexys_starship_hazard_gen with a game-level reference model.
module tb_nexys_starship_hazard_gen;

    localparam logic [15:0] SEED = 16'h0000;
    localparam int          TD   = 8;
    localparam logic [7:0]  BT   = 8'd100;
    localparam int          CD   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nexys_starship_hazard_gen_if bus();

    nexys_starship_hazard_gen #(
        .LFSR_SEED(SEED), .TICK_DIV(TD), .BREAK_THRESH(BT), .COOLDOWN_TICKS(CD)
    ) dut (
        .Clk(clk), .Reset(rst), .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: game view of the generator.
    logic [15:0] m_lfsr;
    int          m_div;
    bit          m_timer;
    logic [3:0]  m_pulse;
    logic [3:0]  m_hex;
    int          m_count;
    bit          m_playing;
    int          m_cool;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        if (v == 16'h0000) return 16'h0001;
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int level_thr(input logic [1:0] lvl);
        int t;
        if (lvl == 2'd3) return 255;
        t = int'(BT) * (1 << lvl);
        return (t > 255) ? 255 : t;
    endfunction

    function automatic logic [3:0] obs_pulse();
        return {bus.LR_random, bus.RR_random, bus.UR_random, bus.DR_random};
    endfunction

    task automatic model_update(input bit r, input bit play, input bit go, input logic [1:0] lvl);
        bit         tick;
        logic [3:0] onehot;
        logic [3:0] nib;
        if (r) begin
            m_lfsr = (SEED == 16'h0000) ? 16'h0001 : SEED;
            m_div = 0; m_timer = 0; m_pulse = 4'h0; m_hex = 4'h1;
            m_count = 0; m_playing = 0; m_cool = 0;
            return;
        end
        tick    = (m_div == TD - 1);
        m_pulse = 4'h0;
        if (go) begin
            m_playing = 0;
            m_cool    = 0;
        end else if (!m_playing) begin
            if (play) begin
                m_playing = 1;
                m_count   = 0;
            end
        end else if (tick) begin
            if (m_cool > 0) begin
                m_cool--;
            end else if (int'(m_lfsr[7:0]) < level_thr(lvl)) begin
                onehot  = 4'b1000;
                m_pulse = onehot >> m_lfsr[9:8];
                nib     = m_lfsr[15:12];
                m_hex   = (nib == 4'h0) ? 4'h1 : nib;
                m_count = (m_count >= 255) ? 255 : m_count + 1;
                m_cool  = CD;
            end
        end
        m_lfsr  = lfsr_next(m_lfsr);
        m_div   = (m_div + 1) % TD;
        m_timer = (m_div >= TD / 2);
    endtask

    // Advance one clock; inputs are sampled by the model as they stand before the edge.
    task automatic step();
        model_update(rst, bus.play_flag, bus.gameover_ctrl, bus.level);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.play_flag = 1'b0; bus.gameover_ctrl = 1'b0; bus.level = 2'd0;
        step(); step();
        rst = 1'b0;
        checks++; if (dut.lfsr_q !== 16'h0001) begin errors++; $display("FAIL reset_lfsr got=%h exp=%h", dut.lfsr_q, 16'h0001); end
        checks++; if (bus.timer_clk !== 1'b0) begin errors++; $display("FAIL reset_timer got=%b exp=0", bus.timer_clk); end
        checks++; if (bus.random_hex !== 4'h1) begin errors++; $display("FAIL reset_hex got=%h exp=1", bus.random_hex); end
        checks++; if (bus.break_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.break_count); end
        checks++; if (obs_pulse() !== 4'h0) begin errors++; $display("FAIL reset_pulse got=%b exp=0000", obs_pulse()); end
        for (int k = 1; k <= 3 * TD; k++) begin
            step();
            checks++;
            if (bus.timer_clk !== 1'((k % TD) >= TD / 2)) begin
                errors++; $display("FAIL timer_pattern k=%0d got=%b exp=%b", k, bus.timer_clk, (k % TD) >= TD / 2);
            end
            checks++;
            if (dut.lfsr_q !== m_lfsr) begin errors++; $display("FAIL lfsr_seq k=%0d got=%h exp=%h", k, dut.lfsr_q, m_lfsr); end
        end
    endtask

    task automatic test_idle_then_play();
        bit found = 0;
        bus.level = 2'd3;
        for (int k = 0; k < 100; k++) begin
            step();
            checks++;
            if (obs_pulse() !== 4'h0) begin errors++; $display("FAIL idle_pulse k=%0d got=%b exp=0000", k, obs_pulse()); end
        end
        repeat ($urandom_range(0, 7)) step();
        bus.play_flag = 1'b1; step(); bus.play_flag = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            step();
            checks++;
            if (obs_pulse() !== m_pulse) begin errors++; $display("FAIL first_pulse k=%0d got=%b exp=%b", k, obs_pulse(), m_pulse); end
            if (m_pulse != 4'h0) begin
                found = 1;
                checks++;
                if ($countones(obs_pulse()) != 1) begin errors++; $display("FAIL first_onehot got=%b exp=one-hot", obs_pulse()); end
                checks++;
                if (bus.random_hex !== m_hex) begin errors++; $display("FAIL first_hex got=%h exp=%h", bus.random_hex, m_hex); end
                step();
                checks++;
                if (obs_pulse() !== 4'h0) begin errors++; $display("FAIL pulse_width got=%b exp=0000", obs_pulse()); end
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL first_pulse_timeout got=none exp=pulse within 64 cycles"); end
    endtask

    task automatic test_spacing();
        int last = -1000;
        int npulse = 0;
        int base = m_count;
        bus.level = 2'd3;
        for (int k = 0; k < 400; k++) begin
            step();
            checks++;
            if (obs_pulse() !== m_pulse) begin errors++; $display("FAIL spacing_pulse k=%0d got=%b exp=%b", k, obs_pulse(), m_pulse); end
            checks++;
            if (bus.random_hex === 4'h0 || bus.random_hex !== m_hex) begin
                errors++; $display("FAIL spacing_hex k=%0d got=%h exp=%h", k, bus.random_hex, m_hex);
            end
            if (obs_pulse() != 4'h0) begin
                checks++;
                if (cyc - last < (CD + 1) * TD) begin errors++; $display("FAIL spacing_gap got=%0d exp>=%0d", cyc - last, (CD + 1) * TD); end
                last = cyc;
                npulse++;
            end
        end
        checks++;
        if (int'(bus.break_count) != base + npulse) begin
            errors++; $display("FAIL spacing_count got=%0d exp=%0d", bus.break_count, base + npulse);
        end
    endtask

    task automatic test_thresholds();
        int exp_thr [4] = '{100, 200, 255, 255};
        for (int lvl = 0; lvl < 4; lvl++) begin
            bus.level = 2'(lvl);
            step();
            checks++;
            if (int'(dut.thr_c) != exp_thr[lvl]) begin errors++; $display("FAIL thr_lvl%0d got=%0d exp=%0d", lvl, dut.thr_c, exp_thr[lvl]); end
            for (int k = 0; k < 200 + int'($urandom_range(0, 100)); k++) begin
                step();
                checks++;
                if (obs_pulse() !== m_pulse || bus.random_hex !== m_hex || int'(bus.break_count) != m_count) begin
                    errors++;
                    $display("FAIL thr_model lvl=%0d k=%0d got=%b/%h/%0d exp=%b/%h/%0d", lvl, k,
                             obs_pulse(), bus.random_hex, bus.break_count, m_pulse, m_hex, m_count);
                end
            end
        end
    endtask

    task automatic test_gameover_tick();
        bit found = 0;
        int saved;
        bus.level = 2'd3;
        for (int k = 0; k < 300 && !found; k++) begin
            if (m_playing && m_cool == 0 && m_div == TD - 1 && int'(m_lfsr[7:0]) < 255) begin
                found = 1;
                saved = m_count;
                bus.gameover_ctrl = 1'b1; step(); bus.gameover_ctrl = 1'b0;
                checks++;
                if (obs_pulse() !== 4'h0) begin errors++; $display("FAIL gameover_pulse got=%b exp=0000", obs_pulse()); end
                checks++;
                if (int'(bus.break_count) != saved) begin errors++; $display("FAIL gameover_count got=%0d exp=%0d", bus.break_count, saved); end
                for (int j = 0; j < 40; j++) begin
                    step();
                    checks++;
                    if (obs_pulse() !== 4'h0) begin errors++; $display("FAIL gameover_idle j=%0d got=%b exp=0000", j, obs_pulse()); end
                end
            end else begin
                step();
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL gameover_search got=none exp=winning tick within 300 cycles"); end
        // play and gameover together keep the game idle
        bus.play_flag = 1'b1; bus.gameover_ctrl = 1'b1; step();
        bus.play_flag = 1'b0; bus.gameover_ctrl = 1'b0;
        for (int j = 0; j < 40; j++) begin
            step();
            checks++;
            if (obs_pulse() !== 4'h0) begin errors++; $display("FAIL both_idle j=%0d got=%b exp=0000", j, obs_pulse()); end
        end
        bus.play_flag = 1'b1; step(); bus.play_flag = 1'b0;
        checks++;
        if (bus.break_count !== 8'd0) begin errors++; $display("FAIL replay_clear got=%0d exp=0", bus.break_count); end
    endtask

    task automatic test_saturation();
        int after = 0;
        bit reached = 0;
        bus.level = 2'd3;
        bus.play_flag = 1'b1;     // held high while running: must not clear the count
        for (int k = 0; k < 12000; k++) begin
            step();
            checks++;
            if (obs_pulse() !== m_pulse || int'(bus.break_count) != m_count) begin
                errors++; $display("FAIL sat_model k=%0d got=%b/%0d exp=%b/%0d", k, obs_pulse(), bus.break_count, m_pulse, m_count);
            end
            if (reached && m_pulse != 4'h0) after++;
            if (m_count == 255) reached = 1;
            if (after >= 4) break;
        end
        bus.play_flag = 1'b0;
        checks++;
        if (bus.break_count !== 8'd255) begin errors++; $display("FAIL sat_count got=%0d exp=255", bus.break_count); end
        checks++;
        if (after < 4) begin errors++; $display("FAIL sat_pulses got=%0d exp>=4", after); end
    endtask

    task automatic test_midgame_reset();
        bit found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            step();
            if (m_pulse != 4'h0) found = 1;
        end
        checks++;
        if (!found || obs_pulse() === 4'h0) begin errors++; $display("FAIL midreset_setup got=%b exp=pulse", obs_pulse()); end
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if (obs_pulse() !== 4'h0) begin errors++; $display("FAIL midreset_pulse got=%b exp=0000", obs_pulse()); end
        checks++; if (bus.break_count !== 8'd0) begin errors++; $display("FAIL midreset_count got=%0d exp=0", bus.break_count); end
        checks++; if (bus.random_hex !== 4'h1) begin errors++; $display("FAIL midreset_hex got=%h exp=1", bus.random_hex); end
        checks++; if (bus.timer_clk !== 1'b0) begin errors++; $display("FAIL midreset_timer got=%b exp=0", bus.timer_clk); end
        checks++; if (dut.lfsr_q !== 16'h0001) begin errors++; $display("FAIL midreset_lfsr got=%h exp=0001", dut.lfsr_q); end
        for (int j = 0; j < 40; j++) begin
            step();
            checks++;
            if (obs_pulse() !== 4'h0) begin errors++; $display("FAIL midreset_idle j=%0d got=%b exp=0000", j, obs_pulse()); end
        end
    endtask

    initial begin
        bus.play_flag = 1'b0;
        bus.gameover_ctrl = 1'b0;
        bus.level = 2'd0;
        test_reset();
        test_idle_then_play();
        test_spacing();
        test_thresholds();
        test_gameover_tick();
        test_saturation();
        test_midgame_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
